// File: rtl/icache_intc_pkg.sv
// Shared types and constants for the icache interconnect request routing.
package icache_intc_pkg;

  // Weighted-round phase: which requester group is currently preferred.
  typedef enum logic {
    PHASE_CORE = 1'b0,
    PHASE_AUX  = 1'b1
  } phase_e;

  localparam int DEFAULT_CORE_WEIGHT = 8;
  localparam int DEFAULT_AUX_WEIGHT  = 1;

  // Width of a credit counter that must hold values up to max(a,b)-1.
  function automatic int credit_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/rr_arb_icache_intc.sv
// Round-robin arbiter for one requester group. The winner is the first
// requesting index at or after the pointer (wrapping); the pointer moves to
// winner+1 only when the caller reports that the winner was accepted.
module rr_arb_icache_intc #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic         any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_idx;

  // Wrapping search from the pointer for the first active request.
  always_comb begin
    int idx;
    idx     = 0;
    any     = 1'b0;
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!any && req[idx]) begin
        any     = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  // One-hot grant for the winner, empty when nobody requests.
  always_comb begin
    gnt          = '0;
    gnt[win_idx] = any;
  end

  // Pointer update on an accepted grant only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
    end
  end

endmodule

// File: rtl/routing_block_wrr_req_icache_intc.sv
// Request router for the icache interconnect: weighted round-robin between a
// core group and an aux group, a 2-entry request buffer towards the cache
// banks, and one-hot response routing back to the requesters.
//
// Handshake: upstream channel i transfers when request_i[i] & grant_o[i];
// grant_o never depends on anything the requester drives after seeing it,
// and a grant is only issued when the buffer has room. Downstream transfers
// when request_o & grant_i; address_o/UID_o hold until that happens.
// UID_WIDTH must equal N_CORES+N_AUX_CHANNEL (one-hot requester IDs).
module routing_block_wrr_req_icache_intc
  import icache_intc_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int N_CORES       = 16,
  parameter int N_AUX_CHANNEL = 1,
  parameter int UID_WIDTH     = N_CORES + N_AUX_CHANNEL,
  parameter int CORE_WEIGHT   = DEFAULT_CORE_WEIGHT,
  parameter int AUX_WEIGHT    = DEFAULT_AUX_WEIGHT
) (
  input  logic                                                     clk_i,
  input  logic                                                     rst_ni,
  input  logic                                                     aux_strict_i,
  input  logic [N_CORES+N_AUX_CHANNEL-1:0]                         request_i,
  input  logic [N_CORES+N_AUX_CHANNEL-1:0][ADDRESS_WIDTH-1:0]      address_i,
  input  logic [N_CORES+N_AUX_CHANNEL-1:0][UID_WIDTH-1:0]          UID_i,
  output logic [N_CORES+N_AUX_CHANNEL-1:0]                         grant_o,
  output logic                                                     request_o,
  output logic [ADDRESS_WIDTH-1:0]                                 address_o,
  output logic [UID_WIDTH-1:0]                                     UID_o,
  input  logic                                                     grant_i,
  input  logic                                                     response_i,
  input  logic [UID_WIDTH-1:0]                                     response_UID_i,
  output logic [N_CORES+N_AUX_CHANNEL-1:0]                         response_o,
  output phase_e                                                   phase_o,
  output logic [credit_width(CORE_WEIGHT, AUX_WEIGHT)-1:0]         credit_o
);

  localparam int NT = N_CORES + N_AUX_CHANNEL;
  localparam int CW = credit_width(CORE_WEIGHT, AUX_WEIGHT);

  // Group arbiters
  logic [N_CORES-1:0]       core_gnt;
  logic [N_AUX_CHANNEL-1:0] aux_gnt;
  logic                     core_any;
  logic                     aux_any;
  logic                     core_adv;
  logic                     aux_adv;

  // Weighted-round state
  phase_e                   phase_q;
  phase_e                   phase_d;
  logic [CW-1:0]            count_q;
  logic [CW-1:0]            count_d;
  logic [CW-1:0]            weight_m1;
  logic                     sel_aux;
  logic                     pref_hs;

  // Request buffer
  logic [ADDRESS_WIDTH-1:0] addr_mem [2];
  logic [UID_WIDTH-1:0]     uid_mem  [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               fill;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic [ADDRESS_WIDTH-1:0] push_addr;
  logic [UID_WIDTH-1:0]     push_uid;

  rr_arb_icache_intc #(.N(N_CORES)) u_core_arb (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (request_i[N_CORES-1:0]),
    .advance (core_adv),
    .gnt     (core_gnt),
    .any     (core_any)
  );

  rr_arb_icache_intc #(.N(N_AUX_CHANNEL)) u_aux_arb (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req     (request_i[NT-1:N_CORES]),
    .advance (aux_adv),
    .gnt     (aux_gnt),
    .any     (aux_any)
  );

  // Phase FSM state register: phase and credit count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= PHASE_CORE;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  // Phase FSM next state: only preferred-group acceptances spend credit.
  always_comb begin
    phase_d   = phase_q;
    count_d   = count_q;
    weight_m1 = (phase_q == PHASE_CORE) ? CW'(CORE_WEIGHT - 1) : CW'(AUX_WEIGHT - 1);
    if (pref_hs) begin
      if (count_q == weight_m1) begin
        phase_d = (phase_q == PHASE_CORE) ? PHASE_AUX : PHASE_CORE;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  // Phase FSM outputs: group selection, grant fan-out and arbiter advances.
  always_comb begin
    if (aux_strict_i || phase_q == PHASE_AUX) begin
      sel_aux = aux_any;
    end else begin
      sel_aux = !core_any;
    end
    push     = rst_ni && !full && (core_any || aux_any);
    core_adv = push && !sel_aux;
    aux_adv  = push && sel_aux;
    pref_hs  = push && !aux_strict_i && (sel_aux == (phase_q == PHASE_AUX));
    grant_o  = '0;
    if (push) begin
      grant_o = sel_aux ? {aux_gnt, {N_CORES{1'b0}}} : {{N_AUX_CHANNEL{1'b0}}, core_gnt};
    end
  end

  // Payload of the granted channel.
  always_comb begin
    push_addr = '0;
    push_uid  = '0;
    for (int i = 0; i < NT; i++) begin
      if (grant_o[i]) begin
        push_addr = push_addr | address_i[i];
        push_uid  = push_uid | UID_i[i];
      end
    end
  end

  assign full  = (fill == 2'd2);
  assign empty = (fill == 2'd0);
  assign pop   = !empty && grant_i;

  // Two-entry buffer; a full buffer refuses pushes even while popping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        addr_mem[i] <= '0;
        uid_mem[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      fill   <= 2'd0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= push_addr;
        uid_mem[wr_ptr]  <= push_uid;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 2'd1;
        2'b01:   fill <= fill - 2'd1;
        default: fill <= fill;
      endcase
    end
  end

  assign request_o  = !empty;
  assign address_o  = addr_mem[rd_ptr];
  assign UID_o      = uid_mem[rd_ptr];
  assign response_o = {NT{response_i}} & response_UID_i;
  assign phase_o    = phase_q;
  assign credit_o   = count_q;

endmodule

// File: tb/tb_routing_block_wrr_req_icache_intc.sv
// Directed bench for the icache request router: 4 cores, 2 aux channels,
// core weight 3, aux weight 1, one-hot UIDs.
module tb_routing_block_wrr_req_icache_intc;
  import icache_intc_pkg::*;

  localparam int AW = 32;
  localparam int NC = 4;
  localparam int NA = 2;
  localparam int NT = NC + NA;
  localparam int UW = NT;
  localparam int CW = credit_width(3, 1);
  localparam int EW = UW + AW;

  logic                   clk;
  logic                   rst_ni;
  logic                   aux_strict_i;
  logic [NT-1:0]          request_i;
  logic [NT-1:0][AW-1:0]  address_i;
  logic [NT-1:0][UW-1:0]  UID_i;
  logic [NT-1:0]          grant_o;
  logic                   request_o;
  logic [AW-1:0]          address_o;
  logic [UW-1:0]          UID_o;
  logic                   grant_i;
  logic                   response_i;
  logic [UW-1:0]          response_UID_i;
  logic [NT-1:0]          response_o;
  phase_e                 phase_o;
  logic [CW-1:0]          credit_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];

  routing_block_wrr_req_icache_intc #(
    .ADDRESS_WIDTH (AW),
    .N_CORES       (NC),
    .N_AUX_CHANNEL (NA),
    .UID_WIDTH     (UW),
    .CORE_WEIGHT   (3),
    .AUX_WEIGHT    (1)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .aux_strict_i   (aux_strict_i),
    .request_i      (request_i),
    .address_i      (address_i),
    .UID_i          (UID_i),
    .grant_o        (grant_o),
    .request_o      (request_o),
    .address_o      (address_o),
    .UID_o          (UID_o),
    .grant_i        (grant_i),
    .response_i     (response_i),
    .response_UID_i (response_UID_i),
    .response_o     (response_o),
    .phase_o        (phase_o),
    .credit_o       (credit_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [NT-1:0] onehot(input int ch);
    logic [NT-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int ch);
    return 32'hA000_0000 + AW'(ch * 16);
  endfunction

  function automatic logic [EW-1:0] ent(input int ch, input logic [AW-1:0] a);
    return {onehot(ch), a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 20) begin
      next_cycle();
      w++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard monitor: every downstream transfer must match the queue head.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_ni && request_o && grant_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none", {UID_o, address_o});
        end else begin
          e = exp_q.pop_front();
          check("out_entry", 64'({UID_o, address_o}), 64'(e));
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int seq31[12];
    seq31 = '{0, 1, 2, 4, 3, 0, 1, 5, 2, 3, 0, 4};

    rst_ni         = 1'b0;
    aux_strict_i   = 1'b0;
    request_i      = '1;
    grant_i        = 1'b0;
    response_i     = 1'b0;
    response_UID_i = '0;
    for (int i = 0; i < NT; i++) begin
      address_i[i] = addr_of(i);
      UID_i[i]     = onehot(i);
    end

    // Reset state, requests high but no grant during reset
    #3;
    check("rst_request_o", 64'(request_o), 64'(0));
    check("rst_address_o", 64'(address_o), 64'(0));
    check("rst_uid_o", 64'(UID_o), 64'(0));
    check("rst_grant_o", 64'(grant_o), 64'(0));
    check("rst_phase", 64'(phase_o), 64'(PHASE_CORE));
    check("rst_credit", 64'(credit_o), 64'(0));
    next_cycle();
    next_cycle();
    request_i = '0;
    rst_ni    = 1'b1;
    next_cycle();

    // Weighted round with everybody requesting
    request_i = '1;
    grant_i   = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("wrr_grant", 64'(grant_o), 64'(onehot(seq31[k])));
      exp_q.push_back(ent(seq31[k], addr_of(seq31[k])));
      next_cycle();
    end
    request_i = '0;
    @(negedge clk);
    check("wrr_phase_end", 64'(phase_o), 64'(PHASE_CORE));
    check("wrr_credit_end", 64'(credit_o), 64'(0));
    next_cycle();
    wait_drain();

    // Aux-only requests in CORE phase do not touch phase or credit
    request_i = 6'b100000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("aux_only_grant", 64'(grant_o), 64'(onehot(5)));
      check("aux_only_phase", 64'(phase_o), 64'(PHASE_CORE));
      check("aux_only_credit", 64'(credit_o), 64'(0));
      exp_q.push_back(ent(5, addr_of(5)));
      next_cycle();
    end
    request_i = '0;
    wait_drain();

    // Backpressure: two grants fill the buffer, head stays put
    grant_i      = 1'b0;
    request_i    = 6'b000010;
    address_i[1] = 32'h1111_0000;
    @(negedge clk);
    check("bp_grant1", 64'(grant_o), 64'(onehot(1)));
    check("bp_req_o_empty", 64'(request_o), 64'(0));
    exp_q.push_back(ent(1, 32'h1111_0000));
    next_cycle();
    address_i[1] = 32'h2222_0000;
    @(negedge clk);
    check("bp_grant2", 64'(grant_o), 64'(onehot(1)));
    check("bp_latency", 64'(request_o), 64'(1));
    check("bp_head_addr", 64'(address_o), 64'(32'h1111_0000));
    exp_q.push_back(ent(1, 32'h2222_0000));
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_full_grant", 64'(grant_o), 64'(0));
      check("bp_full_req_o", 64'(request_o), 64'(1));
      check("bp_hold_addr", 64'(address_o), 64'(32'h1111_0000));
      check("bp_hold_uid", 64'(UID_o), 64'(onehot(1)));
      next_cycle();
    end
    request_i    = '0;
    grant_i      = 1'b1;
    address_i[1] = addr_of(1);
    wait_drain();

    // Strict aux priority freezes phase and credit (credit is 2 here)
    aux_strict_i = 1'b1;
    request_i    = 6'b010001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("strict_grant", 64'(grant_o), 64'(onehot(4)));
      check("strict_phase", 64'(phase_o), 64'(PHASE_CORE));
      check("strict_credit", 64'(credit_o), 64'(2));
      exp_q.push_back(ent(4, addr_of(4)));
      next_cycle();
    end
    request_i    = '0;
    aux_strict_i = 1'b0;
    wait_drain();

    // Response routing
    response_i     = 1'b1;
    response_UID_i = 6'b000100;
    #1;
    check("resp_ch2", 64'(response_o), 64'(6'b000100));
    response_UID_i = 6'b100000;
    #1;
    check("resp_ch5", 64'(response_o), 64'(6'b100000));
    response_i = 1'b0;
    #1;
    check("resp_off", 64'(response_o), 64'(0));
    response_UID_i = '0;
    next_cycle();

    // Fill the buffer, then reset mid-operation
    grant_i   = 1'b0;
    request_i = '1;
    @(negedge clk);
    check("pre_rst_grant1", 64'(grant_o), 64'(onehot(2)));
    next_cycle();
    @(negedge clk);
    check("pre_rst_phase", 64'(phase_o), 64'(PHASE_AUX));
    check("pre_rst_grant2", 64'(grant_o), 64'(onehot(5)));
    next_cycle();
    @(negedge clk);
    check("pre_rst_full", 64'(grant_o), 64'(0));
    check("pre_rst_head", 64'(UID_o), 64'(onehot(2)));
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_req_o", 64'(request_o), 64'(0));
    check("mid_rst_grant", 64'(grant_o), 64'(0));
    check("mid_rst_addr", 64'(address_o), 64'(0));
    exp_q.delete();
    next_cycle();
    next_cycle();
    rst_ni  = 1'b1;
    grant_i = 1'b1;
    @(negedge clk);
    check("post_rst_grant", 64'(grant_o), 64'(onehot(0)));
    check("post_rst_phase", 64'(phase_o), 64'(PHASE_CORE));
    check("post_rst_credit", 64'(credit_o), 64'(0));
    exp_q.push_back(ent(0, addr_of(0)));
    next_cycle();
    request_i = '0;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
